// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: FSM state encoding, data width and
// the quotient reported for a divide-by-zero.
package arith_pkg;

   localparam int WIDTH = 4;

   localparam logic [WIDTH-1:0] DZ_QUOT = 4'hF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/div4_seq_if.sv
// Request/result bundle of the sequential divider. The requester drives
// start/a/b; the divider drives the status and result lines.
interface div4_seq_if;
   import arith_pkg::*;

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic             dz;

   modport master (
      output start, a, b,
      input  busy, done, q, r, dz
   );

   modport slave (
      input  start, a, b,
      output busy, done, q, r, dz
   );

endinterface

// File: rtl/full_add.sv
// One-bit full adder cell of the arithmetic library.
module full_add (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/sub5.sv
// 5-bit ripple subtractor d = a - b, built as a + ~b + 1 from full_add cells.
// co = 1 means no borrow (a >= b).
module sub5 (
   input  logic [4:0] a,
   input  logic [4:0] b,
   output logic [4:0] d,
   output logic       co
);

   logic [5:0] c_s;

   assign c_s[0] = 1'b1;

   for (genvar i = 0; i < 5; i++) begin : g_bit
      full_add u_fa (
         .a  (a[i]),
         .b  (~b[i]),
         .ci (c_s[i]),
         .s  (d[i]),
         .co (c_s[i+1])
      );
   end

   assign co = c_s[5];

endmodule

// File: rtl/div4_seq.sv
// Sequential 4-bit unsigned restoring divider. One quotient bit per clock,
// MSB first, through a 5-bit ripple subtractor. b == 0 short-circuits to
// DONE with q = 4'hF, r = a and dz set.
module div4_seq
   import arith_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   div4_seq_if.slave bus
);

   state_t           state_r;
   state_t           state_nx_s;
   logic             load_s;
   logic             zero_s;
   logic             iter_s;

   logic [WIDTH-1:0] dvd_r;
   logic [WIDTH-1:0] dvs_r;
   logic [WIDTH-1:0] p_r;
   logic [1:0]       cnt_r;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] r_r;
   logic             dz_r;
   logic             busy_r;
   logic             done_r;

   logic [4:0]       t_s;
   logic [4:0]       diff_s;
   logic             co_s;
   logic             qbit_s;
   logic [WIDTH-1:0] p_nx_s;

   assign t_s = {p_r, dvd_r[WIDTH-1]};

   sub5 u_sub (
      .a  (t_s),
      .b  ({1'b0, dvs_r}),
      .d  (diff_s),
      .co (co_s)
   );

   // Quotient bit and next partial remainder. Because P < divisor, a
   // non-borrowing difference always fits in 4 bits, so diff_s[4] is 0
   // whenever co_s is 1; folding it in keeps the full difference in use.
   always_comb begin
      qbit_s = co_s & ~diff_s[4];
      if (qbit_s) begin
         p_nx_s = diff_s[WIDTH-1:0];
      end else begin
         p_nx_s = t_s[WIDTH-1:0];
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state decode and datapath strobes.
   always_comb begin
      state_nx_s = state_r;
      load_s     = 1'b0;
      zero_s     = 1'b0;
      iter_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               if (bus.b != 4'd0) begin
                  load_s     = 1'b1;
                  state_nx_s = RUN;
               end else begin
                  zero_s     = 1'b1;
                  state_nx_s = DONE;
               end
            end else begin
               state_nx_s = IDLE;
            end
         end
         RUN: begin
            iter_s = 1'b1;
            if (cnt_r == 2'd3) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = RUN;
            end
         end
         DONE: begin
            state_nx_s = IDLE;
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // Operand, remainder, counter and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         dvd_r <= 4'd0;
         dvs_r <= 4'd0;
         p_r   <= 4'd0;
         cnt_r <= 2'd0;
         q_r   <= 4'd0;
         r_r   <= 4'd0;
         dz_r  <= 1'b0;
      end else if (load_s) begin
         dvd_r <= bus.a;
         dvs_r <= bus.b;
         p_r   <= 4'd0;
         cnt_r <= 2'd0;
         dz_r  <= 1'b0;
      end else if (zero_s) begin
         q_r  <= DZ_QUOT;
         r_r  <= bus.a;
         dz_r <= 1'b1;
      end else if (iter_s) begin
         dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
         p_r   <= p_nx_s;
         cnt_r <= cnt_r + 2'd1;
         q_r   <= {q_r[WIDTH-2:0], qbit_s};
         if (cnt_r == 2'd3) begin
            r_r <= p_nx_s;
         end else begin
            r_r <= r_r;
         end
      end
   end

   // Status flags registered from the next state so they track the FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (state_nx_s == RUN);
         done_r <= (state_nx_s == DONE);
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.q    = q_r;
   assign bus.r    = r_r;
   assign bus.dz   = dz_r;

endmodule
